psum_drain: RTL and testbench
=============================

# psum_drain

Bottom-edge drain for the systolic array. It takes the 64-bit partial sums that leave the last PE row and removes the one-cycle-per-column skew that the left-to-right activation flow introduces. Each output row is reassembled into one aligned word and buffered in a small FIFO. Rows are handed to the downstream consumer over a valid/ready handshake.

## Interface
- `num`, 16, number of columns; must match the PE row width, ≥2
- `DEPTH`, 4, FIFO depth in aligned rows; power of two, ≥2
- `CLK` in 1, rising-edge clock
- `RESET` in 1, synchronous, active-low reset
- `EN` in 1, array advance enable; low freezes the de-skew pipeline (same meaning as the array's EN)
- `in_valid` in 1, column 0 of `in_sum` carries row data this cycle; column j of that row arrives j EN-cycles later
- `in_sum` in num*64, bottom-row `out_sum` bus; column j at [(j+1)*64-1:j*64], signed two's complement
- `out_valid` out 1, `out_data` holds an aligned row
- `out_ready` in 1, consumer accepts when high together with `out_valid`
- `out_data` out num*64, aligned row, same column packing as `in_sum`
- `count` out $clog2(DEPTH)+1, FIFO occupancy
- `overflow` out 1, sticky; a completed row was dropped because the FIFO was full

## Operation
- De-skew: column j passes through a delay line of num-1-j registers; column num-1 is registered zero times. All delay registers shift only when EN=1.
- `in_valid` passes through a num-1 stage valid shift register, also gated by EN. When its output is 1 on an EN=1 cycle, the aligned row is pushed into the FIFO.
- Back-to-back `in_valid` on consecutive EN cycles is supported, at full throughput of one row per EN cycle.
- FIFO push and pop:
  - Pop occurs when `out_valid & out_ready`.
  - Push is accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
  - Otherwise the row is discarded and `overflow` is set.
- `count` behaviour:
  - Simultaneous push and pop leaves `count` unchanged.
  - `count` never exceeds DEPTH and never underflows.
- `out_valid` = (count!=0). `out_data` is the FIFO head when `out_valid`=1, otherwise forced to 0.
- The output side ignores EN; draining continues while the array is stalled.
- Values are stored as received, with no width change.
- Reset (RESET=0 at an edge):
  - Clears the valid shift register, FIFO pointers, `count` and `overflow`.
  - Rows in flight are lost.
  - Delay-line data registers need not be reset.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `count`=0, `overflow`=0.
- Latency: `in_valid` sampled at edge t, with EN high for the following num-1 cycles.
  - The push happens at edge t+num-1.
  - `out_valid`=1 from the cycle after, i.e. num cycles after `in_valid` into an empty FIFO.
- Each EN=0 cycle in that window adds one cycle of latency.
- Pop takes effect at the accepting edge. The next head appears the following cycle, with no bubble.
- `overflow` rises in the cycle after the dropped push and stays high until reset.
- The valid pipeline never drops data while EN=0.

## Configuration
- `PSUM_DRAIN_RELU_EN` defined: each 64-bit column is clamped at FIFO write. A negative value (bit 63 set) is written as 0; non-negative values pass unchanged.
- Not defined: values are written unmodified.
- Latency is identical in both cases.

## Test plan
- Basic alignment, num=4, DEPTH=4, EN=1, `out_ready`=1:
  - Stimulus: `in_valid` at t, with column j = 0x10+j presented at t+j.
  - Required: `out_valid` at t+4 for exactly one cycle, with `out_data` columns {0x13,0x12,0x11,0x10} (MSB to LSB).
- Throughput: 8 back-to-back rows, row r column j = r*16+j, `out_ready`=1.
  - Required: 8 consecutive `out_valid` cycles in order, `count`≤1 throughout, `overflow`=0.
- Overflow: `out_ready`=0, 5 rows pushed.
  - Required: `count`=4, `overflow`=1.
  - Then raise `out_ready`: rows 0..3 come out, row 4 is absent, and `overflow` stays 1.
- Full with simultaneous pop: `count`=4, and a push completes on the same edge as a pop.
  - Required: `count` stays 4, `overflow`=0, and the new row becomes the last entry.
- Stall and reset:
  - EN held low for 3 cycles mid-row: `out_valid` is delayed by exactly 3 cycles and data is intact.
  - RESET=0 during a row: next cycle `count`=0, `out_valid`=0, `out_data`=0, and no stale row appears afterwards.
- RELU macro: with `PSUM_DRAIN_RELU_EN` defined, columns {-5, 7, 0x8000000000000000, 0} produce {0, 7, 0, 0}. Without the macro they pass unchanged.

Source files
------------

// File: rtl/psum_drain.sv
// psum_drain: bottom-edge drain for the systolic array.
// Removes the per-column skew from the last PE row's partial sums, reassembles
// each output row into one aligned word and buffers it in a small FIFO that
// drains over a valid/ready handshake.
// Optional feature macro: PSUM_DRAIN_RELU_EN (clamps negative columns to 0 at FIFO write).
module psum_drain #(
  parameter int unsigned num   = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         EN,
  input  logic                         in_valid,
  input  logic [num*64-1:0]            in_sum,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [num*64-1:0]            out_data,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow
);

  localparam int unsigned COL_W = 64;
  localparam int unsigned ROW_W = num * COL_W;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned VS    = num - 1;

  logic [ROW_W-1:0] w_aligned;
  logic [ROW_W-1:0] w_wdata;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_push_ok;
  logic             w_drop;

  logic [VS-1:0]    r_vsr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic [ROW_W-1:0] r_mem [DEPTH];

  // Column j waits num-1-j EN cycles so every column of a row lines up.
  for (genvar j = 0; j < int'(num) - 1; j++) begin : g_dly
    localparam int unsigned LEN = num - 1 - j;
    localparam int unsigned LW  = LEN * COL_W;
    logic [LW-1:0] r_line;

    // Shift this column's delay line on array advance; newest entry at the bottom.
    always_ff @(posedge CLK) begin
      if (EN) begin
        r_line <= (r_line << COL_W) | LW'(in_sum[j*COL_W +: COL_W]);
      end
    end

    assign w_aligned[j*COL_W +: COL_W] = r_line[LW-1 -: COL_W];
  end

  // The last column arrives already aligned.
  assign w_aligned[(num-1)*COL_W +: COL_W] = in_sum[(num-1)*COL_W +: COL_W];

  // Optional clamp of negative columns before they enter the FIFO.
  always_comb begin
    w_wdata = w_aligned;
`ifdef PSUM_DRAIN_RELU_EN
    for (int unsigned c = 0; c < num; c++) begin
      if (w_aligned[c*COL_W + COL_W - 1]) begin
        w_wdata[c*COL_W +: COL_W] = '0;
      end
    end
`endif
  end

  assign w_push    = EN & r_vsr[VS-1];
  assign w_pop     = out_valid & out_ready;
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;

  // Valid pipeline tracks row starts through the de-skew window; frozen when EN=0.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_vsr <= '0;
    end else if (EN) begin
      r_vsr <= (r_vsr << 1) | VS'(in_valid);
    end
  end

  // FIFO storage; a push into a full FIFO with a same-cycle pop reuses the freed slot.
  always_ff @(posedge CLK) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed self-checking bench for psum_drain (num=4, DEPTH=4).
module tb_psum_drain;

  localparam int unsigned N  = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned W  = N * 64;
  localparam int          NS = 64;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         EN;
  logic         in_valid;
  logic [W-1:0] in_sum;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [2:0]   count;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Schedule of rows indexed by the EN step at which column 0 is presented.
  logic [63:0] row_col [NS][N];
  logic        row_v   [NS];
  int          s;

  always #5 CLK = ~CLK;

  psum_drain #(.num(N), .DEPTH(D)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .EN        (EN),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .overflow  (overflow)
  );

  task automatic clear_sched();
    for (int i = 0; i < NS; i++) begin
      row_v[i] = 1'b0;
      for (int j = 0; j < int'(N); j++) row_col[i][j] = 64'h0;
    end
    s = 0;
  endtask

  // Column j of the bus carries the row launched j EN steps ago.
  task automatic drive_inputs();
    in_valid = (s < NS) ? row_v[s] : 1'b0;
    for (int j = 0; j < int'(N); j++) begin
      int idx = s - j;
      if (idx >= 0 && idx < NS && row_v[idx])
        in_sum[j*64 +: 64] = row_col[idx][j];
      else
        in_sum[j*64 +: 64] = 64'hDEAD_BEEF_0000_0000 | 64'(j);
    end
  endtask

  task automatic cyc(input logic en);
    EN = en;
    drive_inputs();
    @(posedge CLK);
    #1;
    if (en) s++;
  endtask

  function automatic logic [W-1:0] exp_row(input int r);
    logic [W-1:0] v;
    for (int j = 0; j < int'(N); j++) v[j*64 +: 64] = row_col[r][j];
    return v;
  endfunction

  task automatic do_reset();
    RESET     = 1'b0;
    out_ready = 1'b0;
    clear_sched();
    cyc(1'b0);
    cyc(1'b0);
    RESET = 1'b1;
    clear_sched();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h exp 0", out_data); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_basic();
    logic [W-1:0] e;
    do_reset();
    out_ready = 1'b1;
    row_v[0] = 1'b1;
    for (int j = 0; j < int'(N); j++) row_col[0][j] = 64'(16 + j);
    e = {64'h13, 64'h12, 64'h11, 64'h10};
    for (int k = 0; k < 7; k++) begin
      cyc(1'b1);
      n_checks++;
      if (out_valid !== (k == 3)) begin n_fail++; $display("FAIL basic_valid k=%0d got %b exp %b", k, out_valid, (k == 3)); end
      if (k == 3) begin
        n_checks++;
        if (out_data !== e) begin n_fail++; $display("FAIL basic_data got %h exp %h", out_data, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int nxt = 0;
    do_reset();
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      row_v[r] = 1'b1;
      for (int j = 0; j < int'(N); j++) row_col[r][j] = 64'(r * 16 + j);
    end
    for (int k = 0; k < 14; k++) begin
      cyc(1'b1);
      n_checks++;
      if (count > 3'd1) begin n_fail++; $display("FAIL b2b_count k=%0d got %0d exp <=1", k, count); end
      n_checks++;
      if (out_valid !== (k >= 3 && k <= 10)) begin n_fail++; $display("FAIL b2b_valid k=%0d got %b exp %b", k, out_valid, (k >= 3 && k <= 10)); end
      if (out_valid === 1'b1 && nxt < 8) begin
        n_checks++;
        if (out_data !== exp_row(nxt)) begin n_fail++; $display("FAIL b2b_data row=%0d got %h exp %h", nxt, out_data, exp_row(nxt)); end
        nxt++;
      end
    end
    n_checks++; if (nxt !== 8) begin n_fail++; $display("FAIL b2b_rows got %0d exp 8", nxt); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int r = 0; r < 5; r++) begin
      row_v[r] = 1'b1;
      for (int j = 0; j < int'(N); j++) row_col[r][j] = 64'(256 * (r + 1) + j);
    end
    for (int k = 0; k < 10; k++) cyc(1'b1);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d exp 4", count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_valid i=%0d got %b exp 1", i, out_valid); end
      n_checks++;
      if (out_data !== exp_row(i)) begin n_fail++; $display("FAIL ovf_drain_data i=%0d got %h exp %h", i, out_data, exp_row(i)); end
      cyc(1'b1);
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_row4_absent got %b exp 0", out_valid); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL ovf_empty_count got %0d exp 0", count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int r = 0; r < 5; r++) begin
      row_v[r] = 1'b1;
      for (int j = 0; j < int'(N); j++) row_col[r][j] = 64'(4096 * (r + 1) + j);
    end
    for (int k = 0; k < 7; k++) cyc(1'b1);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fullpop_pre_count got %0d exp 4", count); end
    out_ready = 1'b1;
    cyc(1'b1);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fullpop_count got %0d exp 4", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_overflow got %b exp 0", overflow); end
    for (int i = 1; i < 5; i++) begin
      n_checks++;
      if (out_data !== exp_row(i)) begin n_fail++; $display("FAIL fullpop_data i=%0d got %h exp %h", i, out_data, exp_row(i)); end
      cyc(1'b1);
    end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL fullpop_end_count got %0d exp 0", count); end
  endtask

  task automatic test_stall();
    logic en;
    do_reset();
    out_ready = 1'b1;
    row_v[0] = 1'b1;
    for (int j = 0; j < int'(N); j++) row_col[0][j] = 64'(160 + j);
    for (int k = 0; k < 9; k++) begin
      en = !(k >= 2 && k <= 4);
      cyc(en);
      n_checks++;
      if (out_valid !== (k == 6)) begin n_fail++; $display("FAIL stall_valid k=%0d got %b exp %b", k, out_valid, (k == 6)); end
      if (k == 6) begin
        n_checks++;
        if (out_data !== exp_row(0)) begin n_fail++; $display("FAIL stall_data got %h exp %h", out_data, exp_row(0)); end
      end
    end
  endtask

  task automatic test_reset_midrow();
    do_reset();
    row_v[0] = 1'b1;
    row_v[3] = 1'b1;
    for (int j = 0; j < int'(N); j++) begin
      row_col[0][j] = 64'(176 + j);
      row_col[3][j] = 64'(192 + j);
    end
    for (int k = 0; k < 5; k++) cyc(1'b1);
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL rst_pre_count got %0d exp 1", count); end
    RESET = 1'b0;
    cyc(1'b1);
    RESET = 1'b1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_data got %h exp 0", out_data); end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stale k=%0d got %b exp 0", k, out_valid); end
    end
  endtask

  task automatic test_relu();
    logic [W-1:0] e;
    do_reset();
    row_v[0] = 1'b1;
    row_col[0][3] = 64'hFFFF_FFFF_FFFF_FFFB;
    row_col[0][2] = 64'h7;
    row_col[0][1] = 64'h8000_0000_0000_0000;
    row_col[0][0] = 64'h0;
`ifdef PSUM_DRAIN_RELU_EN
    e = {64'h0, 64'h7, 64'h0, 64'h0};
`else
    e = {64'hFFFF_FFFF_FFFF_FFFB, 64'h7, 64'h8000_0000_0000_0000, 64'h0};
`endif
    for (int k = 0; k < 4; k++) cyc(1'b1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL relu_valid got %b exp 1", out_valid); end
    n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL relu_data got %h exp %h", out_data, e); end
  endtask

  initial begin
    RESET     = 1'b0;
    EN        = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_stall();
    test_reset_midrow();
    test_relu();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
